// File: rtl/alu_iter_exec_pkg.sv
// Shared definitions for the iterative execute-stage ALU and its decoder.
// Holds the op_to_alu encodings, FSM state encodings and datapath defaults.
// The decoder imports the same package, so these encodings have one source.
package alu_iter_exec_pkg;

  localparam int unsigned DEFAULT_WIDTH   = 16;
  localparam int unsigned DEFAULT_SHAMT_W = 4;

  // op_to_alu encodings. Codes 0xx are the iterative rotates/shifts:
  // bit 1 selects right vs left, bit 0 selects zero-fill vs rotate.
  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_ROR = 3'b010;
  localparam logic [2:0] OP_SRL = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_AND = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  function automatic logic is_shift_op(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Single-bit rotate/shift step, purely combinational.
// Ports:
//   op_i  step kind, matches op_to_alu[1:0]: 00 ROL, 01 SLL, 10 ROR, 11 SRL
//   x_i   value before the step
//   y_o   value after one bit of rotate/shift
module alu_shift_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] x_i,
  output logic [WIDTH-1:0] y_o
);

  logic fill;

  always_comb begin
    y_o  = x_i;
    fill = 1'b0;
    if (op_i[1]) begin
      // Right: the bit entering the MSB is the old LSB for rotate, 0 for shift
      fill = op_i[0] ? 1'b0 : x_i[0];
      y_o  = {fill, x_i[WIDTH-1:1]};
    end else begin
      fill = op_i[0] ? 1'b0 : x_i[WIDTH-1];
      y_o  = {x_i[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/alu_iter_exec.sv
// Execute-stage ALU. Add and logic ops finish in one cycle; rotates/shifts
// run one bit per cycle through alu_shift_step.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   input handshake; in_ready only while idle
//   A, B, invA, invB      operands and per-operand inversion
//   sign                  1: signed overflow rule, 0: unsigned (Ofl = Cout)
//   op_to_alu, cin        operation select and adder carry-in
//   passA, passB          bypass operand to result (passB wins)
//   out_valid / out_ready output handshake; result held until accepted
//   Out, Ofl, Cout, Zero  registered result and flags
module alu_iter_exec
  import alu_iter_exec_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned SHAMT_W = DEFAULT_SHAMT_W  // must equal clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             invA,
  input  logic             invB,
  input  logic             sign,
  input  logic [2:0]       op_to_alu,
  input  logic             cin,
  input  logic             passA,
  input  logic             passB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out,
  output logic             Ofl,
  output logic             Cout,
  output logic             Zero
);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               ofl_q, ofl_d;
  logic               cout_q, cout_d;
  logic               zero_q, zero_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [1:0]         sop_q, sop_d;

  logic [WIDTH-1:0]   a_eff, b_eff;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum;
  logic               add_ofl;
  logic [WIDTH-1:0]   step_y;
  logic [WIDTH-1:0]   res;

  assign a_eff = invA ? ~A : A;
  assign b_eff = invB ? ~B : B;
  assign shamt = b_eff[SHAMT_W-1:0];

  assign sum = {1'b0, a_eff} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

  // Signed overflow: same-sign operands producing a result of the other sign
  assign add_ofl = sign ? ((a_eff[WIDTH-1] == b_eff[WIDTH-1]) &&
                           (sum[WIDTH-1] != a_eff[WIDTH-1]))
                        : sum[WIDTH];

  // Out doubles as the shift working register while in SHIFT
  alu_shift_step #(
    .WIDTH(WIDTH)
  ) u_shift_step (
    .op_i(sop_q),
    .x_i (out_q),
    .y_o (step_y)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ofl_d   = ofl_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    cnt_d   = cnt_q;
    sop_d   = sop_q;
    res     = '0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ofl_d   = 1'b0;
          cout_d  = 1'b0;
          state_d = ST_DONE;
          if (passB) begin
            res = b_eff;
          end else if (passA) begin
            res = a_eff;
          end else begin
            case (op_to_alu)
              OP_ADD: begin
                res    = sum[WIDTH-1:0];
                cout_d = sum[WIDTH];
                ofl_d  = add_ofl;
              end
              OP_OR:  res = a_eff | b_eff;
              OP_XOR: res = a_eff ^ b_eff;
              OP_AND: res = a_eff & b_eff;
              OP_ROL, OP_SLL, OP_ROR, OP_SRL: begin
                res   = a_eff;
                sop_d = op_to_alu[1:0];
                cnt_d = shamt;
                if (is_shift_op(op_to_alu) && (shamt != '0)) begin
                  state_d = ST_SHIFT;
                end
              end
              default: res = a_eff;
            endcase
          end
          out_d  = res;
          zero_d = (res == '0);
        end
      end

      ST_SHIFT: begin
        out_d  = step_y;
        zero_d = (step_y == '0);
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      ofl_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
      sop_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      ofl_q   <= ofl_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
      sop_q   <= sop_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Out       = out_q;
  assign Ofl       = ofl_q;
  assign Cout      = cout_q;
  assign Zero      = zero_q;

endmodule
